// File: rtl/nios_setup_timer_pkg.sv
// nios_setup_timer_pkg: register map, bit positions and control decode for the multi-channel timer
package nios_setup_timer_pkg;
   localparam logic [2:0] REG_STATUS  = 3'd0;
   localparam logic [2:0] REG_CONTROL = 3'd1;
   localparam logic [2:0] REG_PERIOD  = 3'd2;
   localparam logic [2:0] REG_SNAP    = 3'd3;
   localparam logic [2:0] REG_COUNT   = 3'd4;
   localparam int ST_TO       = 0;
   localparam int ST_RUN      = 1;
   localparam int CT_ITO      = 0;
   localparam int CT_CONT     = 1;
   localparam int CT_START    = 2;
   localparam int CT_STOP     = 3;
   localparam int CT_PRESCALE = 8;
   typedef struct packed {
      logic stop;
      logic start;
      logic cont;
      logic ito;
   } ctrl_t;
   function automatic ctrl_t ctrl_decode(input logic [31:0] d);
      return '{stop: d[CT_STOP], start: d[CT_START], cont: d[CT_CONT], ito: d[CT_ITO]};
   endfunction
endpackage

// File: rtl/nios_setup_timer_channel.sv
// nios_setup_timer_channel: one down-counter with prescaler, TO/RUN status and snapshot register
module nios_setup_timer_channel
   import nios_setup_timer_pkg::*;
#(
   parameter int          CNT_W          = 32,
   parameter int          PRESCALE_W     = 8,
   parameter logic [31:0] DEFAULT_PERIOD = 32'h2FAF07F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic [2:0]  reg_sel,
   input  logic [31:0] writedata,
   output logic [31:0] rdata,
   output logic        pending
);
   localparam logic [CNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[CNT_W-1:0];
   logic [CNT_W-1:0]      period, count, snap;
   logic [PRESCALE_W-1:0] prescale, pre_cnt;
   logic                  to, run, ito, cont, reload;
   logic                  wr_status, wr_ctrl, wr_period, wr_snap, start, stop, tick, expire;
   ctrl_t                 ctl;
   assign ctl       = ctrl_decode(writedata);
   assign wr_status = wr && reg_sel == REG_STATUS;
   assign wr_ctrl   = wr && reg_sel == REG_CONTROL;
   assign wr_period = wr && reg_sel == REG_PERIOD;
   assign wr_snap   = wr && reg_sel == REG_SNAP;
   assign start     = wr_ctrl && ctl.start;
   assign stop      = wr_ctrl && ctl.stop;
   // >= rather than == so lowering PRESCALE below the current prescale count still ticks at once
   assign tick      = run && pre_cnt >= prescale;
   assign expire    = tick && count == '0;
   assign pending   = to && ito;
   assign rdata = reg_sel == REG_STATUS  ? 32'({run, to}) :
                  reg_sel == REG_CONTROL ? 32'({prescale, 6'b0, cont, ito}) :
                  reg_sel == REG_PERIOD  ? 32'(period) :
                  reg_sel == REG_SNAP    ? 32'(snap) :
                  reg_sel == REG_COUNT   ? 32'(count) : 32'h0;
   // counter, prescaler and status; a PERIOD write forces a stopped reload on the following cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         period   <= RST_PERIOD;
         count    <= RST_PERIOD;
         snap     <= '0;
         prescale <= '0;
         pre_cnt  <= '0;
         to       <= 1'b0;
         run      <= 1'b0;
         ito      <= 1'b0;
         cont     <= 1'b0;
         reload   <= 1'b0;
      end else begin
         reload <= wr_period;
         if (wr_period) period <= writedata[CNT_W-1:0];
         if (wr_snap) snap <= count;
         if (wr_ctrl) begin
            ito      <= ctl.ito;
            cont     <= ctl.cont;
            prescale <= writedata[CT_PRESCALE +: PRESCALE_W];
         end
         pre_cnt <= (start || wr_period || reload || tick) ? '0 : run ? pre_cnt + 1'b1 : pre_cnt;
         count   <= (reload || expire) ? period : tick ? count - 1'b1 : count;
         to      <= expire || (to && !(wr_status && writedata[ST_TO]));
         run     <= (stop || reload) ? 1'b0 : start ? 1'b1 : expire ? cont : run;
      end
   end
endmodule

// File: rtl/nios_setup_multi_timer.sv
// nios_setup_multi_timer: N-channel interval timer on a 32-bit Avalon-MM slave with combined IRQ
module nios_setup_multi_timer
   import nios_setup_timer_pkg::*;
#(
   parameter int          NUM_CH         = 4,
   parameter int          CNT_W          = 32,
   parameter logic [31:0] DEFAULT_PERIOD = 32'h2FAF07F,
   parameter int          PRESCALE_W     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [$clog2(NUM_CH)+2:0]    address,
   input  logic                         chipselect,
   input  logic                         write_n,
   input  logic [31:0]                  writedata,
   output logic [31:0]                  readdata,
   output logic                         irq,
   output logic [NUM_CH-1:0]            irq_vec
);
   logic [4:0]        ch_sel;
   logic [31:0]       rdata [NUM_CH];
   logic [31:0]       rd_mux;
   logic [NUM_CH-1:0] pend;
   assign ch_sel = 5'(address >> 3);
   for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
      nios_setup_timer_channel #(
         .CNT_W          (CNT_W),
         .PRESCALE_W     (PRESCALE_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .wr        (chipselect && !write_n && ch_sel == 5'(i)),
         .reg_sel   (address[2:0]),
         .writedata (writedata),
         .rdata     (rdata[i]),
         .pending   (pend[i])
      );
   end
   // channel select for the read path; unpopulated channels read 0
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) rd_mux = ch_sel == 5'(i) ? rdata[i] : rd_mux;
   end
   // registered read data and interrupt outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
         irq_vec  <= '0;
         irq      <= 1'b0;
      end else begin
         readdata <= rd_mux;
         irq_vec  <= pend;
         irq      <= |pend;
      end
   end
endmodule

// File: tb/tb_nios_setup_multi_timer.sv
// tb_nios_setup_multi_timer: scoreboard bench for the multi-channel timer (4x32 build and 3x16 build)
module tb_nios_setup_multi_timer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  address = '0;
   logic        cs = 1'b0, cs2 = 1'b0, write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata, readdata2;
   logic        irq, irq2;
   logic [3:0]  irq_vec;
   logic [2:0]  irq_vec2;
   int          checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   nios_setup_multi_timer dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
      .writedata(writedata), .readdata(readdata), .irq(irq), .irq_vec(irq_vec)
   );

   nios_setup_multi_timer #(.NUM_CH(3), .CNT_W(16)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs2), .write_n(write_n),
      .writedata(writedata), .readdata(readdata2), .irq(irq2), .irq_vec(irq_vec2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input bit d2, input int ch, input int r, input logic [31:0] d);
      @(negedge clk);
      address = 5'(ch * 8 + r);
      writedata = d;
      write_n = 1'b0;
      cs = !d2;
      cs2 = d2;
      @(posedge clk);
      #1;
      write_n = 1'b1;
      cs = 1'b0;
      cs2 = 1'b0;
   endtask

   task automatic rd(input bit d2, input int ch, input int r, input string tag, input logic [31:0] exp);
      @(negedge clk);
      address = 5'(ch * 8 + r);
      write_n = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check(tag_q.pop_front(), d2 ? readdata2 : readdata, exp_q.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_readdata", readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_irq_vec", 32'(irq_vec), 32'h0);
      rd(0, 0, 2, "rst_period", 32'h02FAF07F);
      rd(0, 0, 0, "rst_status", 32'h0);
      rd(0, 0, 4, "rst_count", 32'h02FAF07F);

      // ch1: continuous, period 4, prescale 0
      wr(0, 1, 2, 4);
      repeat (1) @(posedge clk);
      wr(0, 1, 1, 32'h7);
      repeat (4) @(posedge clk);
      #1 check("ch1_vec_early", 32'(irq_vec[1]), 32'h0);
      @(posedge clk);
      #1 check("ch1_irq_lag", 32'(irq), 32'h0);
      @(posedge clk);
      #1 check("ch1_irq_vec", 32'(irq_vec), 32'h2);
      check("ch1_irq", 32'(irq), 32'h1);
      rd(0, 1, 0, "ch1_status", 32'h3);
      wr(0, 1, 0, 1);
      @(posedge clk);
      #1 check("ch1_irq_clr", 32'(irq), 32'h0);
      repeat (2) @(posedge clk);
      #1 check("ch1_irq_again", 32'(irq), 32'h1);
      wr(0, 1, 1, 32'h8);
      wr(0, 1, 0, 1);
      rd(0, 1, 1, "ch1_ctrl_stop", 32'h0);

      // ch2: one-shot, period 3, prescale 2
      wr(0, 2, 2, 3);
      repeat (1) @(posedge clk);
      wr(0, 2, 1, 32'h204);
      repeat (11) @(posedge clk);
      rd(0, 2, 0, "ch2_pre_to", 32'h2);
      rd(0, 2, 0, "ch2_to", 32'h1);
      rd(0, 2, 4, "ch2_count", 32'h3);
      rd(0, 2, 1, "ch2_ctrl", 32'h200);

      // ch0: start/stop, snapshot, period write reload
      wr(0, 0, 2, 100);
      repeat (1) @(posedge clk);
      wr(0, 0, 1, 32'h4);
      rd(0, 0, 0, "ch0_run", 32'h2);
      wr(0, 0, 1, 32'hC);
      rd(0, 0, 0, "ch0_stopwins", 32'h0);
      wr(0, 0, 2, 100);
      repeat (1) @(posedge clk);
      wr(0, 0, 1, 32'h4);
      repeat (10) @(posedge clk);
      wr(0, 0, 3, 0);
      rd(0, 0, 3, "ch0_snap", 32'd90);
      wr(0, 0, 2, 50);
      repeat (1) @(posedge clk);
      rd(0, 0, 4, "ch0_reload", 32'd50);
      rd(0, 0, 0, "ch0_reload_stop", 32'h0);
      rd(0, 0, 7, "ch0_reg7", 32'h0);

      // ch3: status clear colliding with expiry
      wr(0, 3, 2, 2);
      repeat (1) @(posedge clk);
      wr(0, 3, 1, 32'h6);
      repeat (5) @(posedge clk);
      wr(0, 3, 0, 1);
      rd(0, 3, 0, "ch3_event_wins", 32'h3);
      wr(0, 3, 0, 1);
      rd(0, 3, 0, "ch3_clear", 32'h2);

      // reset mid-count with a read in flight
      @(negedge clk);
      reset = 1'b1;
      address = 5'(3 * 8 + 4);
      @(posedge clk);
      #1 check("mid_rst_readdata", readdata, 32'h0);
      check("mid_rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd(0, 3, 0, "mid_rst_status", 32'h0);
      rd(0, 3, 4, "mid_rst_count", 32'h02FAF07F);
      rd(0, 3, 2, "mid_rst_period", 32'h02FAF07F);
      rd(0, 1, 1, "mid_rst_ctrl", 32'h0);
      rd(0, 0, 3, "mid_rst_snap", 32'h0);

      // narrow build: truncation and unpopulated channel
      rd(1, 2, 2, "n_rst_period", 32'hF07F);
      wr(1, 0, 2, 32'h12345);
      rd(1, 0, 2, "n_trunc", 32'h2345);
      wr(1, 3, 2, 32'h55);
      rd(1, 3, 2, "n_ch3_read", 32'h0);
      rd(1, 2, 2, "n_ch2_period", 32'hF07F);
      rd(1, 2, 4, "n_ch2_count", 32'hF07F);
      rd(1, 0, 2, "n_ch0_kept", 32'h2345);
      rd(1, 1, 5, "n_reg5", 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
